// File: rtl/bsg_tick_alarm_pkg.sv
// Shared types and default sizes for the tick-driven alarm.
package bsg_tick_alarm_pkg;

    typedef enum logic [1:0] {
        e_idle  = 2'd0,
        e_armed = 2'd1,
        e_fire  = 2'd2
    } state_e;

    localparam int width_default_p      = 16;
    localparam int miss_width_default_p = 4;

endpackage

// File: rtl/bsg_tick_alarm_if.sv
// Configuration and alarm valid/yumi handshake between consumer and alarm block.
interface bsg_tick_alarm_if #(parameter int width_p = 16);

    logic               cfg_v_i;
    logic [width_p-1:0] cfg_period_i;
    logic               cfg_periodic_i;
    logic               cfg_ready_o;
    logic               alarm_v_o;
    logic               alarm_yumi_i;

    modport master (
        output cfg_v_i, cfg_period_i, cfg_periodic_i, alarm_yumi_i,
        input  cfg_ready_o, alarm_v_o
    );

    modport slave (
        input  cfg_v_i, cfg_period_i, cfg_periodic_i, alarm_yumi_i,
        output cfg_ready_o, alarm_v_o
    );

endinterface

// File: rtl/bsg_tick_alarm_ctr.sv
// Clear/increment tick counter with terminal compare against the latched period.
module bsg_tick_alarm_ctr
    import bsg_tick_alarm_pkg::*;
#(
    parameter int width_p = width_default_p
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               clear_i,
    input  logic               en_i,
    input  logic [width_p-1:0] period_i,
    output logic [width_p-1:0] ticks_o,
    output logic               expire_o
);

    logic [width_p-1:0] ticks_r;

    // Terminal tick wraps the count instead of incrementing.
    assign expire_o = en_i & (ticks_r == (period_i - width_p'(1)));
    assign ticks_o  = ticks_r;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)    ticks_r <= '0;
        else if (clear_i)  ticks_r <= '0;
        else if (expire_o) ticks_r <= '0;
        else if (en_i)     ticks_r <= ticks_r + width_p'(1);
    end

endmodule

// File: rtl/bsg_tick_alarm.sv
// Programmable tick alarm, one-shot or periodic, with valid/yumi alarm handshake.
// Define BSG_TICK_ALARM_MISS_COUNT_EN to add the saturating alarm_miss_o counter.
module bsg_tick_alarm
    import bsg_tick_alarm_pkg::*;
#(
    parameter int width_p      = width_default_p,
    parameter int miss_width_p = miss_width_default_p
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    tick_i,
    input  logic                    stop_i,
    bsg_tick_alarm_if.slave         bus,
    output logic                    busy_o,
`ifdef BSG_TICK_ALARM_MISS_COUNT_EN
    output logic [miss_width_p-1:0] alarm_miss_o,
`endif
    output logic [width_p-1:0]      ticks_o
);

    state_e             state_r, state_n;
    logic [width_p-1:0] period_r;
    logic               periodic_r;
    logic               alarm_v_r;
    logic               load, ctr_clear, ctr_en, expire, miss_inc;

    bsg_tick_alarm_ctr #(.width_p(width_p)) ctr (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .clear_i  (ctr_clear),
        .en_i     (ctr_en),
        .period_i (period_r),
        .ticks_o  (ticks_o),
        .expire_o (expire)
    );

    always_comb begin
        state_n   = state_r;
        load      = 1'b0;
        ctr_clear = 1'b0;
        ctr_en    = 1'b0;
        miss_inc  = 1'b0;
        if (stop_i) begin
            state_n   = e_idle;
            ctr_clear = 1'b1;
        end else begin
            case (state_r)
                e_idle: begin
                    // A zero period is consumed but never arms.
                    if (bus.cfg_v_i && (bus.cfg_period_i != '0)) begin
                        load      = 1'b1;
                        ctr_clear = 1'b1;
                        state_n   = e_armed;
                    end
                end
                e_armed: begin
                    ctr_en = tick_i;
                    if (expire) state_n = e_fire;
                end
                e_fire: begin
                    ctr_en = tick_i & periodic_r;
                    if (bus.alarm_yumi_i)
                        state_n = expire ? e_fire : (periodic_r ? e_armed : e_idle);
                    else if (expire)
                        miss_inc = 1'b1;
                end
                default: state_n = e_idle;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r    <= e_idle;
            period_r   <= '0;
            periodic_r <= 1'b0;
            alarm_v_r  <= 1'b0;
        end else begin
            state_r   <= state_n;
            alarm_v_r <= (state_n == e_fire);
            if (load) begin
                period_r   <= bus.cfg_period_i;
                periodic_r <= bus.cfg_periodic_i;
            end
        end
    end

`ifdef BSG_TICK_ALARM_MISS_COUNT_EN
    logic [miss_width_p-1:0] miss_r;

    // Survives stop so software can still read it; only a fresh arm clears it.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)                    miss_r <= '0;
        else if (load)                     miss_r <= '0;
        else if (miss_inc && (miss_r != '1)) miss_r <= miss_r + miss_width_p'(1);
    end

    assign alarm_miss_o = miss_r;
`endif

    assign bus.alarm_v_o   = alarm_v_r;
    assign bus.cfg_ready_o = (state_r == e_idle);
    assign busy_o          = (state_r != e_idle);

endmodule

// File: tb/tb_bsg_tick_alarm.sv
// Scoreboard bench for bsg_tick_alarm: a cycle model queues expected outputs, compared after each edge.
module tb_bsg_tick_alarm;

    localparam int W  = 16;
    localparam int MW = 4;

    typedef struct {
        logic         av;
        logic         cr;
        logic         busy;
        logic [W-1:0] ticks;
        logic [MW-1:0] miss;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic tick = 1'b0;
    logic stop = 1'b0;
    logic busy;
    logic [W-1:0] ticks;
    logic [MW-1:0] miss;

    bsg_tick_alarm_if #(.width_p(W)) bus ();

    always #5 clk = ~clk;

    bsg_tick_alarm #(.width_p(W), .miss_width_p(MW)) dut (
        .clk_i       (clk),
        .reset_n_i   (reset_n),
        .tick_i      (tick),
        .stop_i      (stop),
        .bus         (bus),
        .busy_o      (busy),
`ifdef BSG_TICK_ALARM_MISS_COUNT_EN
        .alarm_miss_o(miss),
`endif
        .ticks_o     (ticks)
    );

`ifndef BSG_TICK_ALARM_MISS_COUNT_EN
    assign miss = '0;
`endif

    int n_err = 0;
    int n_chk = 0;
    exp_t sb[$];

    // Reference model state: 0 idle, 1 armed, 2 fire.
    int          m_st;
    logic [W-1:0] m_ticks, m_per;
    logic        m_periodic;
    logic [MW-1:0] m_miss;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_ticks = '0; m_per = '0; m_periodic = 1'b0; m_miss = '0;
    endtask

    task automatic model_step(input logic cv, input logic [W-1:0] per, input logic pm,
                              input logic tk, input logic sp, input logic ym);
        logic ex;
        if (sp) begin
            m_st = 0; m_ticks = '0;
        end else if (m_st == 0) begin
            if (cv && per != 0) begin
                m_per = per; m_periodic = pm; m_ticks = '0; m_miss = '0; m_st = 1;
            end
        end else if (m_st == 1) begin
            if (tk) begin
                if (m_ticks == m_per - 1) begin m_ticks = '0; m_st = 2; end
                else m_ticks = m_ticks + 1;
            end
        end else begin
            ex = m_periodic && tk && (m_ticks == m_per - 1);
            if (m_periodic && tk) m_ticks = ex ? '0 : m_ticks + 1;
            if (ym) m_st = ex ? 2 : (m_periodic ? 1 : 0);
            else if (ex) begin
`ifdef BSG_TICK_ALARM_MISS_COUNT_EN
                if (m_miss != '1) m_miss = m_miss + 1;
`endif
            end
        end
    endtask

    task automatic compare_out();
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        check("alarm_v", {31'd0, bus.alarm_v_o}, {31'd0, e.av});
        check("cfg_ready", {31'd0, bus.cfg_ready_o}, {31'd0, e.cr});
        check("busy", {31'd0, busy}, {31'd0, e.busy});
        check("ticks", {16'd0, ticks}, {16'd0, e.ticks});
        check("miss", {28'd0, miss}, {28'd0, e.miss});
    endtask

    // One clock: drive at negedge, queue the model's prediction, compare after the edge.
    task automatic cyc(input logic cv, input logic [W-1:0] per, input logic pm,
                       input logic tk, input logic sp, input logic ym);
        exp_t e;
        @(negedge clk);
        bus.cfg_v_i = cv; bus.cfg_period_i = per; bus.cfg_periodic_i = pm;
        tick = tk; stop = sp; bus.alarm_yumi_i = ym;
        model_step(cv, per, pm, tk, sp, ym);
        e.av = (m_st == 2); e.cr = (m_st == 0); e.busy = (m_st != 0);
        e.ticks = m_ticks; e.miss = m_miss;
        sb.push_back(e);
        @(posedge clk);
        #1;
        compare_out();
    endtask

    task automatic idle_cyc(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        bus.cfg_v_i = 1'b0; bus.cfg_period_i = '0; bus.cfg_periodic_i = 1'b0;
        bus.alarm_yumi_i = 1'b0;
        model_reset();
        #12;
        check("rst_alarm_v", {31'd0, bus.alarm_v_o}, 32'd0);
        check("rst_cfg_ready", {31'd0, bus.cfg_ready_o}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ticks", {16'd0, ticks}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        idle_cyc(2);

        // One-shot, period 3: cfg at cycle 0, ticks at 2,5,9, yumi at 12.
        for (int c = 0; c <= 13; c++) begin
            cyc(c == 0, (c == 0) ? W'(3) : W'(0), 1'b0,
                (c == 2 || c == 5 || c == 9), 1'b0, (c == 12));
            if (c == 9)  check("oneshot_fire", {31'd0, bus.alarm_v_o}, 32'd1);
            if (c == 12) check("oneshot_done", {31'd0, bus.cfg_ready_o}, 32'd1);
        end

        // Periodic period 2, ticks every cycle, prompt yumi.
        cyc(1'b1, W'(2), 1'b1, 1'b0, 1'b0, 1'b0);
        check("per2_t0", {16'd0, ticks}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, (m_st == 2));
            check("per2_seq", {16'd0, ticks}, (i % 2 == 0) ? 32'd1 : 32'd0);
        end
        check("per2_nomiss", {28'd0, miss}, 32'd0);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Periodic period 1, ticks every cycle, no yumi for 20 ticks.
        cyc(1'b1, W'(1), 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("sat_alarm_v", {31'd0, bus.alarm_v_o}, 32'd1);
`ifdef BSG_TICK_ALARM_MISS_COUNT_EN
        check("sat_miss", {28'd0, miss}, 32'd15);
`endif
        // Expiring tick, yumi and stop together: stop wins.
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b1);
        check("stop_alarm_v", {31'd0, bus.alarm_v_o}, 32'd0);
        check("stop_ticks", {16'd0, ticks}, 32'd0);
        check("stop_ready", {31'd0, bus.cfg_ready_o}, 32'd1);

        // Zero period is consumed without arming.
        cyc(1'b1, W'(0), 1'b1, 1'b1, 1'b0, 1'b0);
        check("p0_busy", {31'd0, busy}, 32'd0);
        idle_cyc(1);

        // Maximum period: no expiry after a few ticks.
        cyc(1'b1, W'(16'hFFFF), 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic cv, sp, tk, ym, pm;
            logic [W-1:0] per;
            cv  = ($urandom_range(0, 3) == 0);
            per = W'($urandom_range(0, 4));
            pm  = $urandom_range(0, 1);
            tk  = ($urandom_range(0, 2) == 0);
            sp  = ($urandom_range(0, 40) == 0);
            ym  = (m_st == 2) && ($urandom_range(0, 2) == 0);
            cyc(cv, per, pm, tk, sp, ym);
        end
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset mid-count at ticks=5, checked before the next edge.
        cyc(1'b1, W'(10), 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("pre_rst_ticks", {16'd0, ticks}, 32'd5);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_ticks", {16'd0, ticks}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_alarm_v", {31'd0, bus.alarm_v_o}, 32'd0);
        check("arst_ready", {31'd0, bus.cfg_ready_o}, 32'd1);
        model_reset();
        @(negedge clk);
        tick = 1'b0;
        reset_n = 1'b1;
        idle_cyc(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bsg_tick_alarm.md
# bsg_tick_alarm

Programmable tick-driven alarm placed directly downstream of the free-running period counter: it consumes that counter's one-cycle overflow pulse as `tick_i` and counts ticks up to a software-loaded period. On expiry it raises an alarm event held under a valid/yumi handshake. It supports one-shot and periodic modes. Typical use: 10 M-cycle ticks turned into second/minute-scale timeouts for watchdogs and housekeeping.

## Interface
Parameters:
- `width_p`, default 16: tick counter and period width.
- `miss_width_p`, default 4: missed-alarm counter width. Used only with the configuration macro.

Ports:
- `clk_i` in 1: clock.
- `reset_n_i` in 1: reset, asynchronous and active-low.
- `tick_i` in 1: one-cycle tick pulse from the upstream counter.
- `cfg_v_i` in 1: configuration valid.
- `cfg_period_i` in `width_p`: number of ticks per alarm.
- `cfg_periodic_i` in 1: 1 = periodic, 0 = one-shot.
- `cfg_ready_o` out 1: configuration accepted when `cfg_v_i & cfg_ready_o`.
- `stop_i` in 1: disarm; highest priority.
- `alarm_v_o` out 1: alarm pending.
- `alarm_yumi_i` in 1: consumer takes alarm; legal only while `alarm_v_o`.
- `busy_o` out 1: armed or alarm pending.
- `ticks_o` out `width_p`: current tick count.
- `alarm_miss_o` out `miss_width_p`: saturating missed-alarm count. Present only with the macro.

## Operation
- States: IDLE, ARMED, FIRE. Reset enters IDLE.
- IDLE:
  - `cfg_ready_o`=1.
  - Accepted cfg with period≠0: latch period and mode, clear ticks (and the miss counter if the macro is present), go to ARMED.
  - Accepted cfg with period=0: consumed, no effect, stay in IDLE.
  - Ticks are ignored.
- ARMED:
  - Each `tick_i` increments ticks.
  - A tick arriving with ticks==period−1 is an expiry: ticks←0, go to FIRE.
- FIRE:
  - `alarm_v_o`=1.
  - One-shot mode: ticks frozen at 0. Yumi goes to IDLE.
  - Periodic mode: counting continues. Yumi goes to ARMED.
- Expiry in FIRE without yumi in the same cycle: a missed alarm. With the macro, `alarm_miss_o` increments, saturating at all-ones. Without the macro, the event is dropped.
- Expiry in FIRE with yumi in the same cycle: stay in FIRE, `alarm_v_o` stays high, not counted as a miss.
- `stop_i`: from any state, go to IDLE and clear ticks. Stop wins over cfg, tick and yumi in the same cycle. `alarm_miss_o` is retained.
- `cfg_ready_o`=0 in ARMED and FIRE. Reconfiguration requires a stop or completion of a one-shot.
- Period arithmetic is unsigned `width_p`. Period=1 expires on every tick. The maximum period is 2^`width_p`−1.
- `busy_o` = (state≠IDLE).

## Timing
- All outputs are registered except `cfg_ready_o` and `busy_o`, which decode the state register.
- Reset value of every output is 0, except `cfg_ready_o`=1.
- Asynchronous reset mid-operation clears state, ticks and the miss counter immediately.
- Expiring tick in cycle n: `alarm_v_o`=1 in cycle n+1.
- Yumi in cycle m: `alarm_v_o`=0 in m+1, unless a simultaneous expiry occurs.
- Accepted cfg in cycle n: a tick in cycle n+1 is the first one counted. A tick in cycle n itself is not counted.
- Stop in cycle n: `alarm_v_o`=0 and `cfg_ready_o`=1 in n+1.

## Configuration
- `BSG_TICK_ALARM_MISS_COUNT_EN` defined: `alarm_miss_o` port and saturating counter are present.
- Undefined: port is absent, missed expiries are silently dropped, and all other behaviour is identical.

## Structure
- `bsg_tick_alarm_pkg` holds:
  - the state enum (IDLE/ARMED/FIRE);
  - the default `width_p`/`miss_width_p` constants.
- Sub-module `bsg_tick_alarm_ctr` contains:
  - a `width_p` clear/increment tick counter;
  - the terminal compare against the latched period;
  - a one-cycle `expire_o` output.
- The FSM, the handshake and the miss counter stay in the top module.

## Test plan
- One-shot: cfg period=3, periodic=0; ticks at cycles 2, 5, 9 → `alarm_v_o`=1 at cycle 10. Yumi at 12 → IDLE and `cfg_ready_o`=1 at 13.
- Periodic, period=2, yumi each alarm promptly → an alarm follows every 2nd tick, `ticks_o` sequence 0, 1, 0, 1, and `alarm_miss_o` stays 0.
- Periodic, period=1, ticks every cycle, no yumi for 20 ticks → `alarm_miss_o` saturates at 15 (macro on). With the macro off, `alarm_v_o` stays 1 and nothing else changes.
- Same cycle tick-expiry, yumi and stop → next cycle IDLE, `alarm_v_o`=0, `ticks_o`=0.
- Cfg period=0 → accepted, state stays IDLE, `busy_o`=0.
- Assert `reset_n_i` low mid-count (ticks=5) between clock edges → outputs are 0 before the next edge.
